// File: rtl/lsu_axi_wr_gpio_bridge.sv
// AXI4 write-channel slave terminating the LSU write port onto NCH 32-bit output registers.
// Single-beat writes merge by byte strobe; bursts are drained and answered with SLVERR.
module lsu_axi_wr_gpio_bridge #(
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 3,
  parameter int                ADDR_W    = 32,
  parameter int                NCH       = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hD000_0000,
  parameter logic [31:0]       CH_RST    = 32'h0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic [NCH*32-1:0]   ch_data,
  output logic [NCH-1:0]      ch_upd
);

  localparam int LANES = DATA_W / 32;
  localparam int SW    = DATA_W / 8;
  localparam int IW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t              state, state_nx;
  logic                aw_full, aw_full_nx, w_full, w_full_nx;
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len, len_nx;
  logic [DATA_W-1:0]   w_data;
  logic [SW-1:0]       w_strb;
  logic                w_last;
  logic                aw_cap, w_cap;
  logic                bvalid_nx;
  logic [ID_W-1:0]     bid_nx;
  logic [1:0]          bresp_nx;
  logic [NCH*32-1:0]   ch_nx;
  logic [NCH-1:0]      upd_nx;
  logic                dec_err;
  logic [IW-1:0]       rel_word;
  logic [LANES-1:0]    lane_act;
  logic [IW-1:0]       lane_idx [LANES];
  logic                unused_awsize;

  // awsize carries no information here: the strobes alone select bytes
  assign unused_awsize = ^awsize;

  assign awready = ~aw_full & ~wb_rst_i;
  assign wready  = (~w_full | (state == DRAIN)) & ~wb_rst_i;
  assign aw_cap  = awvalid & awready;
  assign w_cap   = wvalid & wready;

  // Address decode of the buffered beat and byte-strobe merge into the registers
  always_comb begin
    rel_word = IW'((aw_addr & ~ADDR_W'(SW - 1)) >> 2'd2) - IW'(BASE_ADDR >> 2'd2);
    dec_err  = (aw_addr < BASE_ADDR);
    for (int j = 0; j < LANES; j++) begin
      lane_act[j] = |w_strb[4*j +: 4];
      lane_idx[j] = rel_word + IW'(j);
      dec_err     = dec_err | (lane_act[j] & (lane_idx[j] >= IW'(NCH)));
    end
    // an all-zero strobe touches nothing, so it can never fault
    dec_err = dec_err & (|w_strb);
    ch_nx  = ch_data;
    upd_nx = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int k = 0; k < NCH; k++) begin
        upd_nx[k] = upd_nx[k] | ((state == ISSUE) & ~dec_err & lane_act[j] & (lane_idx[j] == IW'(k)));
        for (int b = 0; b < 4; b++) begin
          ch_nx[32*k+8*b +: 8] = ((state == ISSUE) & ~dec_err & lane_act[j] &
                                  (lane_idx[j] == IW'(k)) & w_strb[4*j+b]) ?
                                 w_data[32*j+8*b +: 8] : ch_nx[32*k+8*b +: 8];
        end
      end
    end
  end

  // Next-state logic; IDLE looks at buffer occupancy including this cycle's captures
  always_comb begin
    state_nx   = state;
    aw_full_nx = aw_full | aw_cap;
    w_full_nx  = w_full | w_cap;
    len_nx     = aw_cap ? awlen : aw_len;
    bvalid_nx  = bvalid;
    bid_nx     = bid;
    bresp_nx   = bresp;
    case (state)
      IDLE: begin
        if (aw_full_nx && (len_nx != 8'd0)) begin
          state_nx = DRAIN;
        end else if (aw_full_nx && w_full_nx) begin
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        aw_full_nx = 1'b0;
        w_full_nx  = 1'b0;
        bvalid_nx  = 1'b1;
        bid_nx     = aw_id;
        bresp_nx   = dec_err ? 2'b10 : 2'b00;
        state_nx   = RESP;
      end
      DRAIN: begin
        // the buffered beat is consumed every cycle; a new beat may refill it
        w_full_nx = w_cap;
        if (w_full && w_last) begin
          aw_full_nx = 1'b0;
          bvalid_nx  = 1'b1;
          bid_nx     = aw_id;
          bresp_nx   = 2'b10;
          state_nx   = RESP;
        end else begin
          state_nx = DRAIN;
        end
      end
      RESP: begin
        if (bready) begin
          bvalid_nx = 1'b0;
          state_nx  = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, channel buffers, B channel and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_id   <= '0;
      aw_addr <= '0;
      aw_len  <= 8'd0;
      w_data  <= '0;
      w_strb  <= '0;
      w_last  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= 2'b00;
      ch_data <= {NCH{CH_RST}};
      ch_upd  <= '0;
    end else begin
      state   <= state_nx;
      aw_full <= aw_full_nx;
      w_full  <= w_full_nx;
      if (aw_cap) begin
        aw_id   <= awid;
        aw_addr <= awaddr;
        aw_len  <= awlen;
      end
      if (w_cap) begin
        w_data <= wdata;
        w_strb <= wstrb;
        w_last <= wlast;
      end
      bvalid  <= bvalid_nx;
      bid     <= bid_nx;
      bresp   <= bresp_nx;
      ch_data <= ch_nx;
      ch_upd  <= upd_nx;
    end
  end

endmodule

// File: tb/tb_lsu_axi_wr_gpio_bridge.sv
// Directed bench for lsu_axi_wr_gpio_bridge with hand-computed register images.
module tb_lsu_axi_wr_gpio_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         awvalid, awready;
  logic [2:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         wvalid, wready;
  logic [63:0]  wdata;
  logic [7:0]   wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [2:0]   bid;
  logic [1:0]   bresp;
  logic [127:0] ch_data;
  logic [3:0]   ch_upd;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_reg [4];

  lsu_axi_wr_gpio_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .ch_data(ch_data), .ch_upd(ch_upd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int k);
    return ch_data[32*k +: 32];
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < 4; k++) check_eq($sformatf("%s_reg%0d", tag, k), reg_of(k), exp_reg[k]);
  endtask

  // single-beat write with bready=1, called on a falling edge with the bridge idle
  task automatic wr_single(input string tag, input logic [2:0] id, input logic [31:0] addr,
                           input logic [63:0] data, input logic [7:0] strb,
                           input logic [1:0] exp_resp, input logic [3:0] exp_upd);
    logic got;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'd0;
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bvalid) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({tag, "_bvalid"}, got, 1'b1);
    check_eq({tag, "_bresp"}, bresp, exp_resp);
    check_eq({tag, "_bid"}, bid, id);
    check_eq({tag, "_upd"}, ch_upd, exp_upd);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcount;
    rst = 1'b1; bready = 1'b1; awsize = 3'd3;
    awvalid = 1'b0; awid = 3'd0; awaddr = 32'd0; awlen = 8'd0;
    wvalid = 1'b0; wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0;
    for (int k = 0; k < 4; k++) exp_reg[k] = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_awready", awready, 1'b0);
    check_eq("rst_wready", wready, 1'b0);
    check_eq("rst_bvalid", bvalid, 1'b0);
    check_eq("rst_bid", bid, 3'd0);
    check_eq("rst_bresp", bresp, 2'b00);
    check_eq("rst_upd", ch_upd, 4'd0);
    check_regs("rst");
    rst = 1'b0;
    #1;
    check_eq("rel_awready", awready, 1'b1);
    check_eq("rel_wready", wready, 1'b1);
    @(negedge clk);

    // upper lane of a 64-bit beat lands in register 1
    awvalid = 1'b1; awid = 3'd3; awaddr = 32'hD000_0004; awlen = 8'd0;
    wvalid = 1'b1; wdata = {32'hCAFE_BABE, 32'h0}; wstrb = 8'hF0; wlast = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("t1_bvalid_e0", bvalid, 1'b0);
    check_eq("t1_upd_e0", ch_upd, 4'd0);
    @(negedge clk);
    exp_reg[1] = 32'hCAFE_BABE;
    check_eq("t1_bvalid_e1", bvalid, 1'b1);
    check_eq("t1_bresp", bresp, 2'b00);
    check_eq("t1_bid", bid, 3'd3);
    check_eq("t1_upd_e1", ch_upd, 4'b0010);
    check_regs("t1");
    @(negedge clk);
    check_eq("t1_bvalid_e2", bvalid, 1'b0);
    check_eq("t1_upd_e2", ch_upd, 4'd0);

    // byte-strobe merge, then both lanes reaching the top register
    wr_single("t2a", 3'd1, 32'hD000_0000, {32'h0, 32'h1122_3344}, 8'h0F, 2'b00, 4'b0001);
    exp_reg[0] = 32'h1122_3344;
    wr_single("t2b", 3'd2, 32'hD000_0000, {32'hFFFF_FFFF, 32'hAABB_CCDD}, 8'h05, 2'b00, 4'b0001);
    exp_reg[0] = 32'h11BB_33DD;
    check_regs("t2b");
    wr_single("t2c", 3'd1, 32'hD000_0008, {32'h5566_7788, 32'h99AA_BBCC}, 8'hFF, 2'b00, 4'b1100);
    exp_reg[2] = 32'h99AA_BBCC; exp_reg[3] = 32'h5566_7788;
    check_regs("t2c");

    // W ahead of AW, B back-pressure, next write queued during RESP
    bready = 1'b0;
    wvalid = 1'b1; wdata = {32'h1357_2468, 32'h0}; wstrb = 8'hF0; wlast = 1'b1;
    @(posedge clk); #1 wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_wait_upd", ch_upd, 4'd0);
      check_eq("t3_wait_bvalid", bvalid, 1'b0);
      check_eq("t3_wait_wready", wready, 1'b0);
      check_eq("t3_wait_reg3", reg_of(3), exp_reg[3]);
    end
    awvalid = 1'b1; awid = 3'd5; awaddr = 32'hD000_000C; awlen = 8'd0;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check_eq("t3_bvalid_e0", bvalid, 1'b0);
    check_eq("t3_reg3_e0", reg_of(3), exp_reg[3]);
    @(negedge clk);
    exp_reg[3] = 32'h1357_2468;
    check_eq("t3_bvalid_e1", bvalid, 1'b1);
    check_eq("t3_upd_e1", ch_upd, 4'b1000);
    check_regs("t3");
    awvalid = 1'b1; awid = 3'd6; awaddr = 32'hD000_0000; awlen = 8'd0;
    wvalid = 1'b1; wdata = 64'h42; wstrb = 8'h01; wlast = 1'b1;
    check_eq("t3_resp_awready", awready, 1'b1);
    check_eq("t3_resp_wready", wready, 1'b1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    check_eq("t3_queued_awready", awready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_hold_bvalid", bvalid, 1'b1);
      check_eq("t3_hold_bid", bid, 3'd5);
      check_eq("t3_hold_bresp", bresp, 2'b00);
      check_eq("t3_hold_upd", ch_upd, 4'd0);
      check_eq("t3_hold_reg0", reg_of(0), exp_reg[0]);
    end
    bready = 1'b1;
    @(negedge clk);
    check_eq("t3_bdone_bvalid", bvalid, 1'b0);
    @(negedge clk);
    check_eq("t3_issue_bvalid", bvalid, 1'b0);
    check_eq("t3_issue_reg0", reg_of(0), exp_reg[0]);
    @(negedge clk);
    exp_reg[0] = 32'h11BB_3342;
    check_eq("t3_next_bvalid", bvalid, 1'b1);
    check_eq("t3_next_bid", bid, 3'd6);
    check_eq("t3_next_upd", ch_upd, 4'b0001);
    check_regs("t3_next");
    @(negedge clk);
    check_eq("t3_end_bvalid", bvalid, 1'b0);
    check_eq("t3_end_upd", ch_upd, 4'd0);

    // decode errors and empty strobe
    wr_single("t4a", 3'd3, 32'hD000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, 4'd0);
    wr_single("t4b", 3'd4, 32'hCFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 2'b10, 4'd0);
    wr_single("t4c", 3'd7, 32'hD000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00, 4'd0);
    check_regs("t4");

    // four-beat burst is drained and rejected once
    awvalid = 1'b1; awid = 3'd2; awaddr = 32'hD000_0000; awlen = 8'd3;
    wvalid = 1'b1; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF;
    for (int b = 0; b < 4; b++) begin
      wlast = (b == 3);
      check_eq("t5_wready", wready, 1'b1);
      @(posedge clk); #1 awvalid = 1'b0;
      check_eq("t5_upd", ch_upd, 4'd0);
    end
    wvalid = 1'b0; wlast = 1'b0; awlen = 8'd0;
    bcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("t5_upd_wait", ch_upd, 4'd0);
      if (bvalid) begin
        bcount++;
        check_eq("t5_bresp", bresp, 2'b10);
        check_eq("t5_bid", bid, 3'd2);
      end
    end
    check_eq("t5_bcount", bcount, 1);
    check_regs("t5");

    // reset while a response is pending
    bready = 1'b0;
    awvalid = 1'b1; awid = 3'd1; awaddr = 32'hD000_0000; awlen = 8'd0;
    wvalid = 1'b1; wdata = 64'h77; wstrb = 8'h01; wlast = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_bvalid", bvalid, 1'b1);
    check_eq("t6_reg0", reg_of(0), 32'h11BB_3377);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_reg[k] = 32'h0;
    check_eq("t6_rst_bvalid", bvalid, 1'b0);
    check_eq("t6_rst_upd", ch_upd, 4'd0);
    check_eq("t6_rst_awready", awready, 1'b0);
    check_regs("t6_rst");
    rst = 1'b0; bready = 1'b1;
    bcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bvalid) bcount++;
    end
    check_eq("t6_no_b", bcount, 0);
    check_eq("t6_awready", awready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
